alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-side driver for the team's 4-bit combinational op unit (a, b, 3-bit opcode, 5-bit result).
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered operands and opcode into the op unit, captures the 5-bit result one cycle later, and returns it with a sequence tag over a valid/ready response interface.
- Sits between a test/host command source and the op unit; all timing into the combinational unit is registered.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
TAG_W, 4, width of response sequence tag

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !fifo_full
cmd_opcode  input  3  operation code
cmd_a  input  4  operand a
cmd_b  input  4  operand b
op_a  output  4  registered operand a to op unit
op_b  output  4  registered operand b to op unit
op_code  output  3  registered opcode to op unit
op_result  input  5  combinational result from op unit
rsp_valid  output  1  response held
rsp_ready  input  1  response consumer ready
rsp_data  output  5  captured op_result
rsp_tag  output  TAG_W  sequence number of this response
busy  output  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, FIFO empty (pointers and count 0), op_a/op_b/op_code=0, rsp_valid=0, rsp_data=0, rsp_tag=0, tag counter=0, busy=0, cmd_ready=1 after release.
- Reset mid-operation discards all FIFO contents and any pending response; nothing is emitted after release.
- Push: cmd_valid & cmd_ready writes {opcode,a,b} at the write pointer. Pointers wrap modulo FIFO_DEPTH. Occupancy count is 0..FIFO_DEPTH.
- cmd_ready depends only on the registered count. When full, cmd_ready=0, even if a pop happens in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, load op_* from the FIFO head, pop, and go to ISSUE.
  - ISSUE: one cycle. rsp_data<=op_result, rsp_tag<=tag counter, tag counter increments (wraps at 2^TAG_W), rsp_valid<=1, go to RESP.
  - RESP: hold rsp_valid, rsp_data and rsp_tag stable until rsp_ready. On rsp_valid & rsp_ready:
    - FIFO non-empty: load next head into op_*, pop, go to ISSUE (rsp_valid<=0).
    - FIFO empty: go to IDLE (rsp_valid<=0).
- op_* change only on the load edge and are otherwise held. In IDLE they keep their last value.
- Latency: command accepted on edge T into an empty FIFO with FSM in IDLE -> op_* valid after edge T+1 -> rsp_valid high after edge T+2.
- Throughput: one result per 2 cycles at most with rsp_ready held high.
- Simultaneous push and pop in one cycle is legal when not full; count is unchanged.
- Responses are returned in command order. Tags are consecutive from 0 after reset.
- No arithmetic is done in this block. rsp_data equals op_result exactly as sampled in ISSUE.

Optional Feature:
- Macro: ALU_CMD_CHECK_EN.
- When defined:
  - Adds ports chk_mismatch (output, 1) and chk_err (output, 1, sticky until reset).
  - In ISSUE, a golden model computes the expected 5-bit result from op_a/op_b/op_code, operands zero-extended to 5 bits, result mod 32:
    - 0: a+b
    - 1: a-b
    - 2: a&b
    - 3: a|b
    - 4: ~a
    - 5: a*b
    - 6: a^b
    - 7: a xnor b
  - chk_mismatch is registered with rsp_valid and is valid while rsp_valid is high. It is 1 if op_result differs from the expected value.
  - chk_err sets on any mismatch.
  - Both reset to 0.
- When undefined: the ports and the golden model are absent. Behaviour is otherwise identical.

Test Plan:
- Push opcode 0, a=7, b=9, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=5'h10, rsp_tag=0.
- Push opcode 1 (3,5), opcode 4 (a=5), opcode 5 (15,15), opcode 7 (A,5) back to back -> in-order responses 5'h1E, 5'h1A, 5'h01, 5'h10 with tags 0..3.
- Hold rsp_ready=0 and push 6 commands with FIFO_DEPTH=4:
  - cmd_ready drops after the 5th accept (4 in FIFO plus 1 issued) and rsp_data/rsp_tag stay stable.
  - Release rsp_ready -> all 5 responses drain in order, and the 6th command is then accepted.
- 17 single commands -> rsp_tag runs 0..15 then wraps to 0.
- Assert rst_n low while in RESP with 2 commands queued -> rsp_valid=0 and busy=0 immediately; after release no responses appear.
- With ALU_CMD_CHECK_EN, force op_result=5'h00 for opcode 0 (1,1) -> chk_mismatch=1 with that response, chk_err stays 1 on later correct results.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue/response sequencer in front of the 4-bit combinational op unit.
// Optional result checker enabled by defining ALU_CMD_CHECK_EN.

package alu_cmd_sequencer_pkg;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

endpackage

module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_opcode_i,
    input  logic [3:0]       cmd_a_i,
    input  logic [3:0]       cmd_b_i,
    output logic [3:0]       op_a_o,
    output logic [3:0]       op_b_o,
    output logic [2:0]       op_code_o,
    input  logic [4:0]       op_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [4:0]       rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
`ifdef ALU_CMD_CHECK_EN
    output logic             busy_o,
    output logic             chk_mismatch_o,
    output logic             chk_err_o
`else
    output logic             busy_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e             state_q, state_d;
    cmd_t               mem_q [FIFO_DEPTH];
    cmd_t               cmd_in_c;
    cmd_t               op_q, op_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [4:0]         rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [TAG_W-1:0]   tag_cnt_q, tag_cnt_d;
    logic               push_c, pop_c, fifo_empty_c;

    assign cmd_in_c     = {cmd_opcode_i, cmd_a_i, cmd_b_i};
    assign push_c       = cmd_valid_i & ready_q;
    assign fifo_empty_c = (count_q == '0);

`ifdef ALU_CMD_CHECK_EN
    logic chk_mismatch_q, chk_mismatch_d;
    logic chk_err_q, chk_err_d;

    // Reference result: operands zero-extended to 5 bits, result mod 32
    function automatic logic [4:0] golden_f(input cmd_t c);
        logic [4:0] a5;
        logic [4:0] b5;
        logic [4:0] r;
        a5 = {1'b0, c.a};
        b5 = {1'b0, c.b};
        case (c.opcode)
            3'd0:    r = a5 + b5;
            3'd1:    r = a5 - b5;
            3'd2:    r = a5 & b5;
            3'd3:    r = a5 | b5;
            3'd4:    r = ~a5;
            3'd5:    r = a5 * b5;
            3'd6:    r = a5 ^ b5;
            default: r = ~(a5 ^ b5);
        endcase
        return r;
    endfunction
`endif

    // Sequencer next-state and datapath load/capture
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        tag_cnt_d   = tag_cnt_q;
        pop_c       = 1'b0;
`ifdef ALU_CMD_CHECK_EN
        chk_mismatch_d = chk_mismatch_q;
        chk_err_d      = chk_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty_c) begin
                    op_d    = mem_q[rd_ptr_q];
                    pop_c   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rsp_data_d  = op_result_i;
                rsp_tag_d   = tag_cnt_q;
                tag_cnt_d   = tag_cnt_q + TAG_W'(1);
                rsp_valid_d = 1'b1;
                state_d     = RESP;
`ifdef ALU_CMD_CHECK_EN
                chk_mismatch_d = (op_result_i != golden_f(op_q));
                chk_err_d      = chk_err_q | chk_mismatch_d;
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty_c) begin
                        op_d    = mem_q[rd_ptr_q];
                        pop_c   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; ready and busy are registered from next-cycle values
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d  = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            tag_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            tag_cnt_q   <= tag_cnt_d;
        end
    end

`ifdef ALU_CMD_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_mismatch_q <= 1'b0;
            chk_err_q      <= 1'b0;
        end else begin
            chk_mismatch_q <= chk_mismatch_d;
            chk_err_q      <= chk_err_d;
        end
    end

    assign chk_mismatch_o = chk_mismatch_q;
    assign chk_err_o      = chk_err_q;
`endif

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign op_a_o      = op_q.a;
    assign op_b_o      = op_q.b;
    assign op_code_o   = op_q.opcode;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed scenarios plus random traffic against a queue-based model.
// Define ALU_CMD_CHECK_EN to also exercise the result checker outputs.

module tb_alu_cmd_sequencer;

    localparam int unsigned TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [3:0]       op_a;
    logic [3:0]       op_b;
    logic [2:0]       op_code;
    logic [4:0]       op_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [4:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
`ifdef ALU_CMD_CHECK_EN
    logic             chk_mismatch;
    logic             chk_err;
`endif

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_opcode_i  (cmd_opcode),
        .cmd_a_i       (cmd_a),
        .cmd_b_i       (cmd_b),
        .op_a_o        (op_a),
        .op_b_o        (op_b),
        .op_code_o     (op_code),
        .op_result_i   (op_result),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_tag_o     (rsp_tag),
`ifdef ALU_CMD_CHECK_EN
        .busy_o        (busy),
        .chk_mismatch_o(chk_mismatch),
        .chk_err_o     (chk_err)
`else
        .busy_o        (busy)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural op unit: plain integer arithmetic, low 5 bits kept
    function automatic logic [4:0] ref_op(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = ~a;
            5: r = a * b;
            6: r = a ^ b;
            default: r = ~(a ^ b);
        endcase
        return r[4:0];
    endfunction

    logic bad_mode;
    assign op_result = (bad_mode && op_code == 3'd0 && op_a == 4'd1 && op_b == 4'd1) ? 5'h00
                     : ref_op(int'(op_code), int'(op_a), int'(op_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Model state: accepted commands awaiting a response, and what came back
    logic [10:0] q_cmd [$];
    logic        q_bad [$];
    int          rx_data [$];
    int          rx_tag [$];
    int          exp_tag;
    int          n_acc;
    logic        exp_err;
    logic        hold_prev;
    logic [4:0]  prev_data;
    logic [TAG_W-1:0] prev_tag;
    logic [10:0] mon_cmd;
    logic        mon_bad;
    logic [4:0]  mon_exp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                q_cmd.push_back({cmd_opcode, cmd_a, cmd_b});
                q_bad.push_back(bad_mode && cmd_opcode == 3'd0 && cmd_a == 4'd1 && cmd_b == 4'd1);
                n_acc++;
            end
            if (rsp_valid && hold_prev) begin
                check("rsp_hold_data", int'(rsp_data), int'(prev_data));
                check("rsp_hold_tag", int'(rsp_tag), int'(prev_tag));
            end
            if (rsp_valid && rsp_ready) begin
                if (q_cmd.size() == 0) begin
                    check("spurious_rsp", 1, 0);
                end else begin
                    mon_cmd = q_cmd.pop_front();
                    mon_bad = q_bad.pop_front();
                    mon_exp = mon_bad ? 5'h00
                            : ref_op(int'(mon_cmd[10:8]), int'(mon_cmd[7:4]), int'(mon_cmd[3:0]));
                    check("rsp_data", int'(rsp_data), int'(mon_exp));
                    check("rsp_tag", int'(rsp_tag), exp_tag);
`ifdef ALU_CMD_CHECK_EN
                    exp_err = exp_err | mon_bad;
                    check("chk_mismatch", int'(chk_mismatch), int'(mon_bad));
                    check("chk_err", int'(chk_err), int'(exp_err));
`endif
                    exp_tag = (exp_tag + 1) % (1 << TAG_W);
                    rx_data.push_back(int'(rsp_data));
                    rx_tag.push_back(int'(rsp_tag));
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_tag  = rsp_tag;
        end
    end

    task automatic apply_reset();
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        rsp_ready  = 1'b0;
        bad_mode   = 1'b0;
        rst_n      = 1'b0;
        q_cmd.delete();
        q_bad.delete();
        rx_data.delete();
        rx_tag.delete();
        exp_tag   = 0;
        n_acc     = 0;
        exp_err   = 1'b0;
        hold_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a command and hold it until accepted or the cycle budget runs out
    task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int max_cyc);
        logic ok;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_drain(input int max_cyc);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            if (q_cmd.size() == 0 && !busy && !rsp_valid) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("drain_done", int'(done), 1);
    endtask

    task automatic push_rand(input int max_cyc);
        push(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), max_cyc);
    endtask

    int          exp3 [4];
    logic [10:0] first_cmd;

    initial begin
        rst_n = 1'b0;

        // Reset state after release
        apply_reset();
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_tag", int'(rsp_tag), 0);
        check("rst_op", int'({op_code, op_a, op_b}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);

        // Single command latency: op_* after T+1, response after T+2
        rsp_ready = 1'b1;
        push(3'd0, 4'd7, 4'd9, 5);
        check("lat_t0_busy", int'(busy), 1);
        @(posedge clk); #1;
        check("lat_t1_op_a", int'(op_a), 7);
        check("lat_t1_op_b", int'(op_b), 9);
        check("lat_t1_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk); #1;
        check("lat_t2_rsp_valid", int'(rsp_valid), 1);
        check("lat_t2_rsp_data", int'(rsp_data), 'h10);
        check("lat_t2_rsp_tag", int'(rsp_tag), 0);
        wait_drain(20);
        check("lat_count", rx_data.size(), 1);

        // Back-to-back mixed opcodes, in-order results
        apply_reset();
        rsp_ready = 1'b1;
        push(3'd1, 4'h3, 4'h5, 5);
        push(3'd4, 4'h5, 4'h0, 5);
        push(3'd5, 4'hF, 4'hF, 5);
        push(3'd7, 4'hA, 4'h5, 5);
        wait_drain(30);
        exp3 = '{'h1E, 'h1A, 'h01, 'h10};
        check("b2b_count", rx_data.size(), 4);
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            check("b2b_data", rx_data[i], exp3[i]);
            check("b2b_tag", rx_tag[i], i);
        end

        // Backpressure: full FIFO plus one issued drops cmd_ready
        apply_reset();
        rsp_ready = 1'b0;
        first_cmd = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
        push(first_cmd[10:8], first_cmd[7:4], first_cmd[3:0], 3);
        for (int k = 1; k < 4; k++) push_rand(3);
        check("bp_ready_before_full", int'(cmd_ready), 1);
        push_rand(3);
        check("bp_ready_full", int'(cmd_ready), 0);
        cmd_valid  = 1'b1;
        cmd_opcode = 3'd6;
        cmd_a      = 4'h9;
        cmd_b      = 4'h3;
        repeat (4) begin @(posedge clk); #1; end
        check("bp_ready_held", int'(cmd_ready), 0);
        check("bp_rsp_valid", int'(rsp_valid), 1);
        check("bp_rsp_tag", int'(rsp_tag), 0);
        check("bp_rsp_data", int'(rsp_data),
              int'(ref_op(int'(first_cmd[10:8]), int'(first_cmd[7:4]), int'(first_cmd[3:0]))));
        rsp_ready = 1'b1;
        push(3'd6, 4'h9, 4'h3, 20);
        wait_drain(40);
        check("bp_count", rx_data.size(), 6);

        // Tag wrap over 17 single commands
        apply_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            push_rand(5);
            wait_drain(20);
        end
        check("wrap_count", rx_tag.size(), 17);
        if (rx_tag.size() == 17) begin
            check("wrap_tag15", rx_tag[15], 15);
            check("wrap_tag16", rx_tag[16], 0);
        end

        // Asynchronous reset while holding a response with two queued
        apply_reset();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_rand(3);
        check("mid_rsp_valid_pre", int'(rsp_valid), 1);
        check("mid_busy_pre", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rsp_valid_rst", int'(rsp_valid), 0);
        check("mid_busy_rst", int'(busy), 0);
        apply_reset();
        rsp_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("mid_no_rsp", rx_data.size(), 0);
        check("mid_busy_post", int'(busy), 0);

        // Random traffic against the queue model
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            cmd_valid  = ($urandom_range(0, 1) == 1);
            cmd_opcode = 3'($urandom_range(0, 7));
            cmd_a      = 4'($urandom_range(0, 15));
            cmd_b      = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain(60);
        check("rand_count", rx_data.size(), n_acc);

`ifdef ALU_CMD_CHECK_EN
        // Corrupted result flags mismatch; error stays sticky afterwards
        apply_reset();
        rsp_ready = 1'b1;
        bad_mode  = 1'b1;
        push(3'd0, 4'd1, 4'd1, 5);
        wait_drain(20);
        bad_mode = 1'b0;
        push(3'd0, 4'd2, 4'd3, 5);
        wait_drain(20);
        check("chk_err_sticky", int'(chk_err), 1);
        check("chk_count", rx_data.size(), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
